// File: rtl/cu_pkg.sv
// Shared definitions for the control-unit slice: instruction field layout,
// issue-stage state encoding and the command-bit meanings used by the FSM.
package cu_pkg;

  localparam int unsigned IR_W     = 9;
  localparam int unsigned FLD_W    = 3;
  localparam int unsigned CMD_LSB  = 6;
  localparam int unsigned ADR1_LSB = 3;
  localparam int unsigned ADR2_LSB = 0;

  // Command bit meanings decoded by the downstream FSM
  localparam int unsigned CMD_MOVE_BIT = 1;
  localparam int unsigned CMD_ALU_BIT  = 0;

  typedef enum logic {
    ISS_IDLE,
    ISS_EXEC
  } iss_state_e;

  function automatic logic [FLD_W-1:0] ir_cmd(input logic [IR_W-1:0] instr);
    return instr[CMD_LSB +: FLD_W];
  endfunction

  function automatic logic [FLD_W-1:0] ir_adr1(input logic [IR_W-1:0] instr);
    return instr[ADR1_LSB +: FLD_W];
  endfunction

  function automatic logic [FLD_W-1:0] ir_adr2(input logic [IR_W-1:0] instr);
    return instr[ADR2_LSB +: FLD_W];
  endfunction

endpackage

// File: rtl/cu_ififo.sv
// Instruction FIFO: synchronous, power-of-two depth, occupancy kept in a
// dedicated level register. Head is read combinationally from the read pointer.
module cu_ififo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       Resetn,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  // Full is decoded from registered level only, so a same-edge pop never frees a slot
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // State registers with synchronous flush
  always_ff @(posedge clk) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/cu_issue.sv
// Issue stage: buffers loader instructions and presents one at a time on ir,
// holding it until the FSM strobes done. Counts retirements and flags
// done strobes that arrive with nothing in flight.
module cu_issue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IR_W  = cu_pkg::IR_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   Resetn,
  input  logic                   in_valid,
  input  logic [IR_W-1:0]        in_ir,
  output logic                   in_ready,
  output logic [IR_W-1:0]        ir,
  output logic                   ir_valid,
  input  logic                   done,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       retired,
  output logic                   err
);

  import cu_pkg::*;

  iss_state_e       state_q, state_d;
  logic [IR_W-1:0]  ir_q, ir_d;
  logic             ir_valid_q, ir_valid_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             err_q, err_d;

  logic             pop;
  logic [IR_W-1:0]  head;
  logic             fifo_empty, fifo_full;

  cu_ififo #(
    .DEPTH (DEPTH),
    .WIDTH (IR_W)
  ) u_ififo (
    .clk     (clk),
    .Resetn  (Resetn),
    .push_i  (in_valid),
    .wdata_i (in_ir),
    .pop_i   (pop),
    .rdata_o (head),
    .level_o (level),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign in_ready = !fifo_full;
  assign empty    = fifo_empty;
  assign full     = fifo_full;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign retired  = retired_q;
  assign err      = err_q;

  // Issue sequencing: pop into ir from IDLE, or back-to-back on done in EXEC
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    retired_d  = retired_q;
    err_d      = err_q;
    pop        = 1'b0;
    unique case (state_q)
      ISS_IDLE: begin
        // done with nothing in flight is a protocol violation, never a retire
        if (done) begin
          err_d = 1'b1;
        end
        if (!fifo_empty) begin
          pop        = 1'b1;
          ir_d       = head;
          ir_valid_d = 1'b1;
          state_d    = ISS_EXEC;
        end
      end
      ISS_EXEC: begin
        if (done) begin
          retired_d = retired_q + 1'b1;
          if (!fifo_empty) begin
            pop  = 1'b1;
            ir_d = head;
          end else begin
            ir_valid_d = 1'b0;
            state_d    = ISS_IDLE;
          end
        end
      end
    endcase
  end

  // FSM state and registered outputs; reset discards any in-flight instruction
  always_ff @(posedge clk) begin
    if (!Resetn) begin
      state_q    <= ISS_IDLE;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      retired_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      retired_q  <= retired_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_cu_issue.sv
// Self-checking bench for cu_issue: a hand-derived vector table, directed
// corner sequences and a randomized run against a queue-based reference model.
module tb_cu_issue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned IR_W  = 9;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             Resetn;
  logic             in_valid;
  logic [IR_W-1:0]  in_ir;
  logic             in_ready;
  logic [IR_W-1:0]  ir;
  logic             ir_valid;
  logic             done;
  logic             empty;
  logic             full;
  logic [3:0]       level;
  logic [CNT_W-1:0] retired;
  logic             err;

  always #5 clk = ~clk;

  cu_issue #(
    .DEPTH (DEPTH),
    .IR_W  (IR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .Resetn   (Resetn),
    .in_valid (in_valid),
    .in_ir    (in_ir),
    .in_ready (in_ready),
    .ir       (ir),
    .ir_valid (ir_valid),
    .done     (done),
    .empty    (empty),
    .full     (full),
    .level    (level),
    .retired  (retired),
    .err      (err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue plus the architectural outputs
  logic [IR_W-1:0] mq[$];
  logic [IR_W-1:0] m_ir;
  logic            m_irv;
  int              m_ret;
  logic            m_err;

  function automatic void model_reset();
    mq.delete();
    m_ir  = '0;
    m_irv = 1'b0;
    m_ret = 0;
    m_err = 1'b0;
  endfunction

  function automatic void model_edge(input logic rst_n, input logic v, input logic d,
                                     input logic [IR_W-1:0] din);
    bit accept;
    if (!rst_n) begin
      model_reset();
      return;
    end
    // Acceptance is judged on occupancy before this edge (no full bypass)
    accept = v && (mq.size() < DEPTH);
    if (!m_irv) begin
      if (d) m_err = 1'b1;
      if (mq.size() > 0) begin
        m_ir  = mq.pop_front();
        m_irv = 1'b1;
      end
    end else if (d) begin
      m_ret = (m_ret + 1) % (1 << CNT_W);
      if (mq.size() > 0) m_ir = mq.pop_front();
      else m_irv = 1'b0;
    end
    if (accept) mq.push_back(din);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ir"},       32'(ir),       32'(m_ir));
    chk({tag, "_irv"},      32'(ir_valid), 32'(m_irv));
    chk({tag, "_level"},    32'(level),    32'(mq.size()));
    chk({tag, "_empty"},    32'(empty),    32'(mq.size() == 0));
    chk({tag, "_full"},     32'(full),     32'(mq.size() == DEPTH));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(mq.size() < DEPTH));
    chk({tag, "_retired"},  32'(retired),  32'(m_ret));
    chk({tag, "_err"},      32'(err),      32'(m_err));
  endtask

  // Drive one edge, advance the model, then settle past the edge
  task automatic step(input logic rst_n, input logic v, input logic d,
                      input logic [IR_W-1:0] din);
    Resetn   = rst_n;
    in_valid = v;
    done     = d;
    in_ir    = din;
    @(posedge clk);
    model_edge(rst_n, v, d, din);
    #1;
  endtask

  typedef struct {
    logic            v;
    logic [IR_W-1:0] din;
    logic            d;
    logic [IR_W-1:0] e_ir;
    logic            e_irv;
    logic [3:0]      e_lvl;
    logic [7:0]      e_ret;
    logic            e_err;
  } vec_t;

  vec_t            tbl[22];
  logic [IR_W-1:0] pend[$];
  logic [IR_W-1:0] got[$];
  logic [IR_W-1:0] last_ir;
  logic [IR_W-1:0] rdin;
  bit              acc;
  bit              drained;

  initial begin
    // v, din, done -> ir, ir_valid, level, retired, err
    tbl[0]  = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 4'd0, 8'd0, 1'b0};
    tbl[1]  = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 4'd0, 8'd0, 1'b0};
    tbl[2]  = '{1'b1, 9'h00A, 1'b0, 9'h000, 1'b0, 4'd1, 8'd0, 1'b0};
    tbl[3]  = '{1'b0, 9'h000, 1'b0, 9'h00A, 1'b1, 4'd0, 8'd0, 1'b0};
    tbl[4]  = '{1'b0, 9'h000, 1'b0, 9'h00A, 1'b1, 4'd0, 8'd0, 1'b0};
    tbl[5]  = '{1'b0, 9'h000, 1'b0, 9'h00A, 1'b1, 4'd0, 8'd0, 1'b0};
    tbl[6]  = '{1'b0, 9'h000, 1'b0, 9'h00A, 1'b1, 4'd0, 8'd0, 1'b0};
    tbl[7]  = '{1'b0, 9'h000, 1'b1, 9'h00A, 1'b0, 4'd0, 8'd1, 1'b0};
    tbl[8]  = '{1'b0, 9'h000, 1'b0, 9'h00A, 1'b0, 4'd0, 8'd1, 1'b0};
    tbl[9]  = '{1'b1, 9'h041, 1'b0, 9'h00A, 1'b0, 4'd1, 8'd1, 1'b0};
    tbl[10] = '{1'b1, 9'h092, 1'b0, 9'h041, 1'b1, 4'd1, 8'd1, 1'b0};
    tbl[11] = '{1'b1, 9'h1E3, 1'b0, 9'h041, 1'b1, 4'd2, 8'd1, 1'b0};
    tbl[12] = '{1'b0, 9'h000, 1'b0, 9'h041, 1'b1, 4'd2, 8'd1, 1'b0};
    tbl[13] = '{1'b0, 9'h000, 1'b0, 9'h041, 1'b1, 4'd2, 8'd1, 1'b0};
    tbl[14] = '{1'b0, 9'h000, 1'b1, 9'h092, 1'b1, 4'd1, 8'd2, 1'b0};
    tbl[15] = '{1'b0, 9'h000, 1'b0, 9'h092, 1'b1, 4'd1, 8'd2, 1'b0};
    tbl[16] = '{1'b0, 9'h000, 1'b0, 9'h092, 1'b1, 4'd1, 8'd2, 1'b0};
    tbl[17] = '{1'b0, 9'h000, 1'b1, 9'h1E3, 1'b1, 4'd0, 8'd3, 1'b0};
    tbl[18] = '{1'b0, 9'h000, 1'b0, 9'h1E3, 1'b1, 4'd0, 8'd3, 1'b0};
    tbl[19] = '{1'b0, 9'h000, 1'b0, 9'h1E3, 1'b1, 4'd0, 8'd3, 1'b0};
    tbl[20] = '{1'b0, 9'h000, 1'b1, 9'h1E3, 1'b0, 4'd0, 8'd4, 1'b0};
    tbl[21] = '{1'b0, 9'h000, 1'b1, 9'h1E3, 1'b0, 4'd0, 8'd4, 1'b1};

    model_reset();
    Resetn   = 1'b0;
    in_valid = 1'b0;
    done     = 1'b0;
    in_ir    = '0;

    // Reset held for two cycles
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("rst_ir",       32'(ir),       32'h0);
    chk("rst_irv",      32'(ir_valid), 32'h0);
    chk("rst_level",    32'(level),    32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_empty",    32'(empty),    32'h1);
    chk("rst_full",     32'(full),     32'h0);
    chk("rst_retired",  32'(retired),  32'h0);
    chk("rst_err",      32'(err),      32'h0);

    // Table: idle, single instruction, back-to-back A/B/C, spurious done
    for (int i = 0; i < 22; i++) begin
      step(1'b1, tbl[i].v, tbl[i].d, tbl[i].din);
      chk($sformatf("tbl%0d_ir", i),      32'(ir),       32'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_irv", i),     32'(ir_valid), 32'(tbl[i].e_irv));
      chk($sformatf("tbl%0d_level", i),   32'(level),    32'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d_retired", i), 32'(retired),  32'(tbl[i].e_ret));
      chk($sformatf("tbl%0d_err", i),     32'(err),      32'(tbl[i].e_err));
    end

    // Full / wrap: nine pushes with done low, a tenth held off, then drain + 4 more
    step(1'b0, 1'b0, 1'b0, '0);
    got.delete();
    last_ir = '0;
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 1'b1, 1'b0, 9'(9'h100 + k));
      check_model("fill");
      if (ir_valid && (got.size() == 0)) begin
        got.push_back(ir);
        last_ir = ir;
      end
      if (k == 8) chk("fill_level7", 32'(level), 32'd7);
      if (k == 9) begin
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_level8", 32'(level), 32'd8);
      end
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 1'b0, 9'h10A);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_level",    32'(level),    32'd8);
    end
    pend.delete();
    for (int k = 10; k <= 14; k++) pend.push_back(9'(9'h100 + k));
    drained = 1'b0;
    for (int c = 0; c < 120; c++) begin
      acc = (pend.size() > 0) && (mq.size() < DEPTH);
      step(1'b1, pend.size() > 0, (c % 2 == 1) && m_irv,
           (pend.size() > 0) ? pend[0] : 9'h000);
      if (acc) void'(pend.pop_front());
      check_model("drain");
      if (ir_valid && (ir != last_ir)) begin
        got.push_back(ir);
        last_ir = ir;
      end
      if ((pend.size() == 0) && (mq.size() == 0) && !m_irv) begin
        drained = 1'b1;
        break;
      end
    end
    chk("drain_finished", 32'(drained), 32'd1);
    chk("wrap_count", 32'(got.size()), 32'd14);
    for (int k = 0; k < got.size() && k < 14; k++) begin
      chk($sformatf("wrap_order%0d", k), 32'(got[k]), 32'(9'h101 + k));
    end
    chk("wrap_retired", 32'(retired), 32'd14);

    // Simultaneous push and pop at level 2
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 9'h0C1);
    step(1'b1, 1'b1, 1'b0, 9'h0C2);
    step(1'b1, 1'b1, 1'b0, 9'h0C3);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("sim_pre_level", 32'(level), 32'd2);
    chk("sim_pre_ir",    32'(ir),    32'h0C1);
    step(1'b1, 1'b1, 1'b1, 9'h0C4);
    chk("sim_level", 32'(level), 32'd2);
    chk("sim_ir",    32'(ir),    32'h0C2);
    check_model("sim");
    step(1'b1, 1'b0, 1'b1, '0);
    chk("sim_next_ir", 32'(ir), 32'h0C3);
    step(1'b1, 1'b0, 1'b1, '0);
    chk("sim_last_ir", 32'(ir), 32'h0C4);
    step(1'b1, 1'b0, 1'b1, '0);
    chk("sim_end_irv", 32'(ir_valid), 32'd0);
    chk("sim_end_ret", 32'(retired),  32'd4);

    // Spurious done in IDLE
    step(1'b1, 1'b0, 1'b1, '0);
    chk("spur_err", 32'(err),     32'd1);
    chk("spur_ret", 32'(retired), 32'd4);
    check_model("spur");

    // Reset during EXEC with three entries queued
    step(1'b1, 1'b1, 1'b0, 9'h031);
    step(1'b1, 1'b1, 1'b0, 9'h032);
    step(1'b1, 1'b1, 1'b0, 9'h033);
    step(1'b1, 1'b1, 1'b0, 9'h034);
    chk("mid_pre_level", 32'(level),    32'd3);
    chk("mid_pre_irv",   32'(ir_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("mid_irv",     32'(ir_valid), 32'd0);
    chk("mid_level",   32'(level),    32'd0);
    chk("mid_err",     32'(err),      32'd0);
    chk("mid_retired", 32'(retired),  32'd0);
    step(1'b1, 1'b0, 1'b0, '0);
    check_model("mid_post");

    // Randomized traffic; loader holds its data until accepted
    pend.delete();
    rdin = 9'($urandom);
    for (int c = 0; c < 600; c++) begin
      logic rv, rd, rr;
      rv  = ($urandom_range(0, 9) < 6);
      rd  = ($urandom_range(0, 3) == 0);
      rr  = ($urandom_range(0, 199) != 0);
      acc = rr && rv && (mq.size() < DEPTH);
      step(rr, rv, rd, rdin);
      if (acc) rdin = 9'($urandom);
      check_model("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
